cpu_final_project_pio_gen: RTL and testbench

CPU_FINAL_PROJECT_PIO_GEN -- requirements
Module: cpu_final_project_pio_gen

---
 rtl/cpu_final_project_pio_gen_if.sv | 26 ++
 rtl/cpu_final_project_pio_gen.sv | 115 +++++++++++
 tb/tb_cpu_final_project_pio_gen.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_final_project_pio_gen_if.sv
// Avalon-MM slave bus bundle for the PIO generator: word address, select,
// active-low write strobe, 32-bit write data and zero-wait-state read data.
`timescale 1ns/1ps
interface cpu_final_project_pio_gen_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/cpu_final_project_pio_gen.sv
// Parallel I/O port with output set/clear registers, a synchronized input
// port, per-bit sticky edge capture and a maskable interrupt (edge or level).
`timescale 1ns/1ps
module cpu_final_project_pio_gen #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_TYPE    = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    cpu_final_project_pio_gen_if.slave  bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic [WIDTH-1:0]            out_port,
    output logic                        irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_bits;
    logic             unused_writedata;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    // Bits above WIDTH carry no meaning for this port.
    assign unused_writedata = ^bus.writedata;

    // Output data register: direct load, bit-set and bit-clear views.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (bus.address)
                3'd0:    data_out <= wdata;
                3'd4:    data_out <= data_out | wdata;
                3'd5:    data_out <= data_out & ~wdata;
                default: ;
            endcase
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr && (bus.address == 3'd2)) begin
            irq_mask <= wdata;
        end
    end

    // Two-flop synchronizer for the asynchronous inputs, plus a history flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Per-bit edge detect on the synchronized input, polarity chosen by EDGE_TYPE.
    always_comb begin
        edge_det = s2 ^ s3;
        if (EDGE_TYPE == 0) begin
            edge_det = s2 & ~s3;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~s2 & s3;
        end
    end

    assign clear_bits = (wr && (bus.address == 3'd3)) ? wdata : '0;

    // Sticky capture; a new edge outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clear_bits) | edge_det;
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata[WIDTH-1:0] = s2;
            3'd1:    bus.readdata[WIDTH-1:0] = data_out;
            3'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
            3'd3:    bus.readdata[WIDTH-1:0] = edge_capture;
            default: bus.readdata = '0;
        endcase
    end

    // Interrupt is formed from registers only, so it cannot glitch within a cycle.
    generate
        if (IRQ_TYPE == 1) begin : g_irq_edge
            assign irq = |(edge_capture & irq_mask);
        end else begin : g_irq_level
            assign irq = |(s2 & irq_mask);
        end
    endgenerate

    assign out_port = data_out;

endmodule

// File: tb/tb_cpu_final_project_pio_gen.sv
// Scoreboard bench: three PIO configurations share one stimulus stream and are
// compared against a behavioural model of the register map and input delay line.
`timescale 1ns/1ps
module tb_cpu_final_project_pio_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out0, out1;
    logic [4:0]  out2;
    logic        irq0, irq1, irq2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_final_project_pio_gen_if bus0 ();
    cpu_final_project_pio_gen_if bus1 ();
    cpu_final_project_pio_gen_if bus2 ();

    assign bus0.address = address;    assign bus1.address = address;    assign bus2.address = address;
    assign bus0.chipselect = chipselect; assign bus1.chipselect = chipselect; assign bus2.chipselect = chipselect;
    assign bus0.write_n = write_n;    assign bus1.write_n = write_n;    assign bus2.write_n = write_n;
    assign bus0.writedata = writedata; assign bus1.writedata = writedata; assign bus2.writedata = writedata;

    cpu_final_project_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .out_port(out0), .irq(irq0));
    cpu_final_project_pio_gen #(.WIDTH(8), .RESET_VALUE(8'h5A), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port), .out_port(out1), .irq(irq1));
    cpu_final_project_pio_gen #(.WIDTH(5), .RESET_VALUE(5'h13), .EDGE_TYPE(1), .IRQ_TYPE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port[4:0]), .out_port(out2), .irq(irq2));

    // ---------------- configuration table of the reference model ----------------
    function automatic int cw(int c);
        return (c == 2) ? 5 : 8;
    endfunction
    function automatic logic [31:0] crv(int c);
        case (c)
            0: return 32'hA5;
            1: return 32'h5A;
            default: return 32'h13;
        endcase
    endfunction
    function automatic int cet(int c);  // 0 rising, 1 falling, 2 any
        case (c)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cit(int c);  // 1 edge irq, 0 level irq
        return (c == 1) ? 0 : 1;
    endfunction
    function automatic logic [31:0] mw(int c);
        return (32'h1 << cw(c)) - 32'h1;
    endfunction

    // ---------------- reference model ----------------
    // samp[0] is in_port sampled at the latest clock, samp[1] the value the
    // software sees (two clocks old), samp[2] the one before that.
    logic [31:0] m_out[3];
    logic [31:0] m_mask[3];
    logic [31:0] m_cap[3];
    logic [31:0] samp[3];
    logic [31:0] t_wd, t_new, t_old, t_det;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) begin
                m_out[c] = crv(c);
                m_mask[c] = 32'h0;
                m_cap[c] = 32'h0;
                samp[c] = 32'h0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                t_wd  = writedata & mw(c);
                t_new = samp[1] & mw(c);
                t_old = samp[2] & mw(c);
                case (cet(c))
                    0: t_det = t_new & ~t_old;
                    1: t_det = ~t_new & t_old & mw(c);
                    default: t_det = t_new ^ t_old;
                endcase
                if (chipselect && !write_n) begin
                    case (address)
                        3'd0: m_out[c] = t_wd;
                        3'd2: m_mask[c] = t_wd;
                        3'd3: m_cap[c] = m_cap[c] & ~t_wd;
                        3'd4: m_out[c] = m_out[c] | t_wd;
                        3'd5: m_out[c] = m_out[c] & ~t_wd;
                        default: ;
                    endcase
                end
                m_cap[c] = m_cap[c] | t_det;
            end
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = {24'h0, in_port};
        end
    end

    function automatic logic [31:0] m_rd(int c, logic [2:0] a);
        case (a)
            3'd0: return samp[1] & mw(c);
            3'd1: return m_out[c];
            3'd2: return m_mask[c];
            3'd3: return m_cap[c];
            default: return 32'h0;
        endcase
    endfunction
    function automatic logic [31:0] m_irq(int c);
        if (cit(c) == 1) return {31'h0, |(m_cap[c] & m_mask[c])};
        return {31'h0, |(samp[1] & m_mask[c] & mw(c))};
    endfunction

    // ---------------- DUT observation helpers ----------------
    function automatic logic [31:0] act_out(int c);
        case (c)
            0: return {24'h0, out0};
            1: return {24'h0, out1};
            default: return {27'h0, out2};
        endcase
    endfunction
    function automatic logic [31:0] act_irq(int c);
        case (c)
            0: return {31'h0, irq0};
            1: return {31'h0, irq1};
            default: return {31'h0, irq2};
        endcase
    endfunction
    function automatic logic [31:0] act_rd(int c);
        case (c)
            0: return bus0.readdata;
            1: return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          c;
        logic [2:0]  a;
        logic [31:0] e;
    } rd_t;
    rd_t sbq[$];

    // Monitor: every cycle compare outputs; on read cycles pop read expectations.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("out_port%0d", c), act_out(c), m_out[c]);
            chk($sformatf("irq%0d", c), act_irq(c), m_irq(c));
        end
        if (reset_n && chipselect && write_n) begin
            for (int k = 0; k < 3; k++) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    rd_t r;
                    r = sbq.pop_front();
                    chk($sformatf("readdata%0d_a%0d", r.c, r.a), act_rd(r.c), r.e);
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle();
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask
    task automatic rd(input logic [2:0] a);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b1; address = a;
        for (int c = 0; c < 3; c++) begin
            rd_t r;
            r.c = c; r.a = a; r.e = m_rd(c, a);
            sbq.push_back(r);
        end
    endtask
    task automatic rd_expect(input logic [2:0] a, input logic [31:0] e0);
        rd(a);
        #1 chk($sformatf("direct_rd0_a%0d", a), bus0.readdata, e0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values held while reset_n is low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out0", {24'h0, out0}, 32'hA5);
        chk("rst_irq0", {31'h0, irq0}, 32'h0);
        chk("rst_out1", {24'h0, out1}, 32'h5A);
        chk("rst_out2", {27'h0, out2}, 32'h13);
        reset_n = 1'b1;
        rd_expect(3'd1, 32'hA5);
        rd_expect(3'd2, 32'h0);
        rd_expect(3'd3, 32'h0);

        // Load, set and clear views of the output register.
        wr(3'd0, 32'hFFFF_FF3C); idle();
        chk("out_load", {24'h0, out0}, 32'h3C);
        wr(3'd4, 32'h03); idle();
        chk("out_set", {24'h0, out0}, 32'h3F);
        wr(3'd5, 32'h30); idle();
        chk("out_clear", {24'h0, out0}, 32'h0F);
        rd_expect(3'd1, 32'h0000_000F);

        // Rising edge on bit 0: captured on the third clock.
        idle(); in_port = 8'h01;
        idle();
        rd_expect(3'd3, 32'h0);
        rd_expect(3'd3, 32'h1);
        chk("irq_masked_off", {31'h0, irq0}, 32'h0);
        wr(3'd2, 32'h01); idle();
        chk("irq_after_mask", {31'h0, irq0}, 32'h1);

        // Set wins over a same-cycle clear; a plain clear drops the bit.
        idle(); in_port = 8'h00;
        repeat (4) idle();
        rd_expect(3'd3, 32'h1);
        idle(); in_port = 8'h01;
        idle();
        wr(3'd3, 32'h01);
        idle();
        rd_expect(3'd3, 32'h1);
        wr(3'd3, 32'h01); idle();
        rd_expect(3'd3, 32'h0);
        chk("irq_after_clear", {31'h0, irq0}, 32'h0);

        // Any-edge capture and level irq on bit 7 (config 1).
        wr(3'd2, 32'h80);
        idle(); in_port = 8'h81;
        idle();
        chk("lvl_irq_lag1", {31'h0, irq1}, 32'h0);
        idle();
        chk("lvl_irq_lag2", {31'h0, irq1}, 32'h1);
        idle();
        rd(3'd3);
        #1 chk("any_cap_rise", bus1.readdata & 32'h80, 32'h80);
        wr(3'd3, 32'h80);
        idle(); in_port = 8'h01;
        repeat (3) idle();
        rd(3'd3);
        #1 chk("any_cap_fall", bus1.readdata & 32'h80, 32'h80);
        chk("rise_only_no_fall", bus0.readdata & 32'h80, 32'h0);
        chk("lvl_irq_low", {31'h0, irq1}, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                wr(3'($urandom_range(0, 7)), $urandom);
            end else if (r <= 6) begin
                rd(3'($urandom_range(0, 7)));
            end else if (r == 7) begin
                @(posedge clk); #1;
                chipselect = 1'b0; write_n = 1'b0;
                address = 3'($urandom_range(0, 7)); writedata = $urandom;
            end else begin
                idle();
            end
            if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
        end

        // Asynchronous reset between clock edges while irq is active.
        wr(3'd2, 32'hFF);
        idle(); in_port = 8'h00;
        repeat (4) idle();
        in_port = 8'hFF;
        repeat (4) idle();
        chk("irq_before_reset", {31'h0, irq0}, 32'h1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_irq0", {31'h0, irq0}, 32'h0);
        chk("async_rst_out0", {24'h0, out0}, 32'hA5);
        chk("async_rst_irq1", {31'h0, irq1}, 32'h0);
        chk("async_rst_out2", {27'h0, out2}, 32'h13);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Input held high through reset: one rising capture three clocks later.
        idle();
        rd_expect(3'd3, 32'h0);
        rd_expect(3'd3, 32'hFF);
        repeat (2) idle();
        chk("sb_empty", sbq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
